// File: rtl/systolic_ctrl.sv
// Sequencer for one DIM x DIM signed matrix multiply on the systolic MAC array:
// flush PE pipelines, clear accumulators, stream skewed operands, return C rows.
module systolic_ctrl #(
   parameter  int BITS_AB = 8,
   parameter  int BITS_C  = 16,
   parameter  int DIM     = 8,
   localparam int W       = $clog2(DIM)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   mem_rd_en,
   output logic [W-1:0]           mem_addr,
   input  logic [DIM*BITS_AB-1:0] a_col,
   input  logic [DIM*BITS_AB-1:0] b_row,
   output logic                   sa_en,
   output logic                   sa_wren,
   output logic [W-1:0]           sa_crow,
   output logic [DIM*BITS_AB-1:0] sa_A,
   output logic [DIM*BITS_AB-1:0] sa_B,
   output logic [DIM*BITS_C-1:0]  sa_Cin,
   input  logic [DIM*BITS_C-1:0]  sa_Cout,
   output logic                   c_valid,
   input  logic                   c_ready,
   output logic [W-1:0]           c_row,
   output logic [DIM*BITS_C-1:0]  c_data
);

   localparam int CW = $clog2(3 * DIM);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_CLEAR,
      S_FEED,
      S_READ,
      S_DONE
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          feed_on;
   logic          rd_vld_p1;

   logic signed [BITS_AB-1:0] a_in_p1 [DIM];
   logic signed [BITS_AB-1:0] b_in_p1 [DIM];
   logic signed [BITS_AB-1:0] a_skew [DIM];
   logic signed [BITS_AB-1:0] b_skew [DIM];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         rd_vld_p1 <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         rd_vld_p1 <= mem_rd_en;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      busy      = 1'b0;
      done      = 1'b0;
      mem_rd_en = 1'b0;
      mem_addr  = '0;
      sa_en     = 1'b0;
      sa_wren   = 1'b0;
      sa_crow   = '0;
      c_valid   = 1'b0;
      c_row     = '0;
      c_data    = '0;
      feed_on   = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (start) state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            busy  = 1'b1;
            sa_en = 1'b1;
            if (cnt == CW'(DIM - 1)) begin
               state_nxt = S_CLEAR;
               cnt_nxt   = '0;
            end
         end
         S_CLEAR: begin
            busy    = 1'b1;
            sa_wren = 1'b1;
            sa_crow = cnt[W-1:0];
            if (cnt == CW'(DIM - 1)) begin
               state_nxt = S_FEED;
               cnt_nxt   = '0;
            end
         end
         S_FEED: begin
            busy    = 1'b1;
            sa_en   = 1'b1;
            feed_on = 1'b1;
            if (cnt < CW'(DIM)) begin
               mem_rd_en = 1'b1;
               mem_addr  = cnt[W-1:0];
            end
            // The last skewed product reaches PE(DIM-1,DIM-1) at t = 3*DIM-2.
            if (cnt == CW'(3 * DIM - 2)) begin
               state_nxt = S_READ;
               cnt_nxt   = '0;
            end
         end
         S_READ: begin
            busy    = 1'b1;
            sa_crow = cnt[W-1:0];
            c_valid = 1'b1;
            c_row   = cnt[W-1:0];
            c_data  = sa_Cout;
            cnt_nxt = cnt;
            if (c_ready) begin
               if (cnt == CW'(DIM - 1)) begin
                  state_nxt = S_DONE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // p1: memory data arrives one cycle after the read strobe; gated to zero otherwise
   always_comb begin
      for (int i = 0; i < DIM; i++) begin
         a_in_p1[i] = rd_vld_p1 ? $signed(a_col[i*BITS_AB +: BITS_AB]) : '0;
         b_in_p1[i] = rd_vld_p1 ? $signed(b_row[i*BITS_AB +: BITS_AB]) : '0;
      end
   end

   // skew: lane i is delayed by i cycles; zeros shifted in while idle drain stale lanes
   for (genvar i = 0; i < DIM; i++) begin : g_lane
      if (i == 0) begin : g_direct
         assign a_skew[i] = a_in_p1[i];
         assign b_skew[i] = b_in_p1[i];
      end else begin : g_delay
         logic signed [BITS_AB-1:0] a_dl [i];
         logic signed [BITS_AB-1:0] b_dl [i];
         always_ff @(posedge clk) begin
            a_dl[0] <= a_in_p1[i];
            b_dl[0] <= b_in_p1[i];
            for (int m = 1; m < i; m++) begin
               a_dl[m] <= a_dl[m-1];
               b_dl[m] <= b_dl[m-1];
            end
         end
         assign a_skew[i] = a_dl[i-1];
         assign b_skew[i] = b_dl[i-1];
      end
   end

   always_comb begin
      sa_A = '0;
      sa_B = '0;
      if (feed_on) begin
         for (int i = 0; i < DIM; i++) begin
            sa_A[i*BITS_AB +: BITS_AB] = a_skew[i];
            sa_B[i*BITS_AB +: BITS_AB] = b_skew[i];
         end
      end
   end

   assign sa_Cin = '0;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: operand memory and MAC array models, results checked
// against a plain matrix-multiply reference with random and directed operands.
module tb_systolic_ctrl;
   localparam int BITS_AB = 8;
   localparam int BITS_C  = 16;
   localparam int DIM     = 8;
   localparam int W       = $clog2(DIM);
   localparam int LAT     = 6 * DIM;
   localparam int CHK_W   = DIM * BITS_C;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   start;
   logic                   busy;
   logic                   done;
   logic                   mem_rd_en;
   logic [W-1:0]           mem_addr;
   logic [DIM*BITS_AB-1:0] a_col;
   logic [DIM*BITS_AB-1:0] b_row;
   logic                   sa_en;
   logic                   sa_wren;
   logic [W-1:0]           sa_crow;
   logic [DIM*BITS_AB-1:0] sa_A;
   logic [DIM*BITS_AB-1:0] sa_B;
   logic [DIM*BITS_C-1:0]  sa_Cin;
   logic [DIM*BITS_C-1:0]  sa_Cout;
   logic                   c_valid;
   logic                   c_ready;
   logic [W-1:0]           c_row;
   logic [DIM*BITS_C-1:0]  c_data;

   int a_m [DIM][DIM];
   int b_m [DIM][DIM];
   logic signed [BITS_C-1:0]  acc [DIM][DIM];
   logic signed [BITS_AB-1:0] ar  [DIM][DIM];
   logic signed [BITS_AB-1:0] br  [DIM][DIM];
   logic  scramble;
   int    checks   = 0;
   int    failures = 0;
   string cur_test = "reset";

   systolic_ctrl #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .a_col(a_col), .b_row(b_row),
      .sa_en(sa_en), .sa_wren(sa_wren), .sa_crow(sa_crow), .sa_A(sa_A), .sa_B(sa_B),
      .sa_Cin(sa_Cin), .sa_Cout(sa_Cout), .c_valid(c_valid), .c_ready(c_ready),
      .c_row(c_row), .c_data(c_data)
   );

   always #5 clk = ~clk;

   // operand memory: data one cycle after the strobe, noise otherwise
   always @(posedge clk) begin
      for (int i = 0; i < DIM; i++) begin
         if (mem_rd_en) begin
            a_col[i*BITS_AB +: BITS_AB] <= BITS_AB'(a_m[i][mem_addr]);
            b_row[i*BITS_AB +: BITS_AB] <= BITS_AB'(b_m[mem_addr][i]);
         end else begin
            a_col[i*BITS_AB +: BITS_AB] <= BITS_AB'($urandom);
            b_row[i*BITS_AB +: BITS_AB] <= BITS_AB'($urandom);
         end
      end
   end

   function automatic logic signed [BITS_C-1:0] mul(input logic signed [BITS_AB-1:0] a,
                                                    input logic signed [BITS_AB-1:0] b);
      logic signed [BITS_C-1:0] x;
      logic signed [BITS_C-1:0] y;
      x = a;
      y = b;
      return x * y;
   endfunction

   function automatic logic signed [BITS_AB-1:0] a_in(input int i, input int j);
      if (j == 0) return sa_A[i*BITS_AB +: BITS_AB];
      return ar[i][j-1];
   endfunction

   function automatic logic signed [BITS_AB-1:0] b_in(input int i, input int j);
      if (i == 0) return sa_B[j*BITS_AB +: BITS_AB];
      return br[i-1][j];
   endfunction

   // MAC array: A flows right, B flows down, each PE accumulates a*b
   always @(posedge clk) begin
      for (int i = 0; i < DIM; i++) begin
         for (int j = 0; j < DIM; j++) begin
            if (scramble) begin
               acc[i][j] <= BITS_C'($urandom);
               ar[i][j]  <= BITS_AB'($urandom);
               br[i][j]  <= BITS_AB'($urandom);
            end else begin
               if (sa_wren && i == int'(sa_crow))
                  acc[i][j] <= sa_Cin[j*BITS_C +: BITS_C];
               else if (sa_en)
                  acc[i][j] <= acc[i][j] + mul(a_in(i, j), b_in(i, j));
               if (sa_en) begin
                  ar[i][j] <= a_in(i, j);
                  br[i][j] <= b_in(i, j);
               end
            end
         end
      end
   end

   always_comb begin
      sa_Cout = '0;
      for (int j = 0; j < DIM; j++) sa_Cout[j*BITS_C +: BITS_C] = acc[sa_crow][j];
   end

   task automatic chk(input string tag, input logic [CHK_W-1:0] act, input logic [CHK_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s/%s: actual=%0d expected=%0d", cur_test, tag, act, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_mem"}, {mem_rd_en, mem_addr}, 0);
      chk({tag, "_sactl"}, {sa_en, sa_wren, sa_crow}, 0);
      chk({tag, "_saAB"}, {sa_A, sa_B}, 0);
      chk({tag, "_Cin"}, sa_Cin, 0);
      chk({tag, "_crow"}, {c_valid, c_row}, 0);
      chk({tag, "_cdata"}, c_data, 0);
   endtask

   task automatic set_mats(input int mode);
      for (int i = 0; i < DIM; i++) begin
         for (int j = 0; j < DIM; j++) begin
            case (mode)
               0: begin a_m[i][j] = (i == j) ? 1 : 0; b_m[i][j] = 8 * i + j; end
               1: begin a_m[i][j] = 1;    b_m[i][j] = 1;    end
               2: begin a_m[i][j] = -128; b_m[i][j] = -128; end
               3: begin a_m[i][j] = -128; b_m[i][j] = 127;  end
               4: begin a_m[i][j] = 5;    b_m[i][j] = 5;    end
               5: begin a_m[i][j] = (i == j) ? 1 : 0; b_m[i][j] = (i == j) ? 1 : 0; end
               default: begin
                  a_m[i][j] = int'($urandom_range(0, 255)) - 128;
                  b_m[i][j] = int'($urandom_range(0, 255)) - 128;
               end
            endcase
         end
      end
   endtask

   task automatic run_op(input int stall_row, input int stall_len, input bit rand_ready,
                         input bit start_in_read, input int abort_cyc);
      logic [BITS_C-1:0]      exp_c [DIM][DIM];
      logic [DIM*BITS_AB-1:0] ea;
      logic [DIM*BITS_AB-1:0] eb;
      logic [DIM*BITS_C-1:0]  prev_data;
      int cyc, rd_cnt, rd_first, rd_last, row, stalls, stall_left, t, k, s;
      bit fin, prev_stalled, seen_valid;
      for (int r = 0; r < DIM; r++) begin
         for (int j = 0; j < DIM; j++) begin
            s = 0;
            for (int kk = 0; kk < DIM; kk++) s += a_m[r][kk] * b_m[kk][j];
            exp_c[r][j] = BITS_C'(s);
         end
      end
      cyc = 1; rd_cnt = 0; rd_first = -1; rd_last = -1; row = 0; stalls = 0;
      stall_left = stall_len; fin = 0; prev_stalled = 0; seen_valid = 0; prev_data = '0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      while (!fin && cyc < 20 * DIM + LAT) begin
         if (c_valid && int'(c_row) == stall_row && stall_left > 0) begin
            c_ready = 1'b0;
            stall_left--;
         end else if (rand_ready) begin
            c_ready = ($urandom_range(0, 1) == 1);
         end else begin
            c_ready = 1'b1;
         end
         if (start_in_read) start = c_valid && (int'(c_row) == 2);
         chk("busy", busy, 1);
         chk("sa_Cin", sa_Cin, 0);
         if (cyc <= DIM) begin
            chk("flush_en", sa_en, 1);
            chk("flush_AB", {sa_A, sa_B}, 0);
         end else if (cyc <= 2 * DIM) begin
            chk("clear_wren", {sa_wren, sa_en}, 2);
            chk("clear_row", sa_crow, cyc - DIM - 1);
         end else if (cyc <= 5 * DIM - 1) begin
            t = cyc - 2 * DIM - 1;
            ea = '0;
            eb = '0;
            for (int i = 0; i < DIM; i++) begin
               k = t - 1 - i;
               if (k >= 0 && k < DIM) begin
                  ea[i*BITS_AB +: BITS_AB] = BITS_AB'(a_m[i][k]);
                  eb[i*BITS_AB +: BITS_AB] = BITS_AB'(b_m[k][i]);
               end
            end
            chk("feed_en", sa_en, 1);
            chk("feed_A", sa_A, ea);
            chk("feed_B", sa_B, eb);
         end
         if (mem_rd_en) begin
            chk("mem_addr", mem_addr, rd_cnt);
            if (rd_first < 0) rd_first = cyc;
            rd_last = cyc;
            rd_cnt++;
         end
         if (cyc == abort_cyc) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            c_ready = 1'b1;
            check_idle("after_rst");
            return;
         end
         if (c_valid) begin
            if (!seen_valid) chk("first_valid", cyc, 5 * DIM);
            seen_valid = 1;
            chk("c_row", c_row, row);
            if (prev_stalled) chk("c_hold", c_data, prev_data);
            if (c_ready) begin
               for (int j = 0; j < DIM; j++)
                  if (row < DIM) chk("c_data", c_data[j*BITS_C +: BITS_C], exp_c[row][j]);
               row++;
               prev_stalled = 0;
            end else begin
               stalls++;
               prev_stalled = 1;
               prev_data = c_data;
            end
         end
         if (done) begin
            chk("done_cycle", cyc, LAT + stalls);
            chk("rows", row, DIM);
            fin = 1;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      c_ready = 1'b1;
      if (!fin) chk("timeout", 0, 1);
      chk("rd_count", rd_cnt, DIM);
      chk("rd_first", rd_first, 2 * DIM + 1);
      chk("rd_span", rd_last - rd_first, DIM - 1);
      @(negedge clk);
      chk("post_busy", busy, 0);
      chk("post_done", done, 0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      c_ready = 1'b1;
      scramble = 1'b1;
      repeat (3) @(negedge clk);
      check_idle("in_rst");
      scramble = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check_idle("post_rst");

      cur_test = "identity";   set_mats(0); run_op(-1, 0, 0, 0, 0);
      cur_test = "ones";       set_mats(1); run_op(-1, 0, 0, 0, 0);
      cur_test = "neg_neg";    set_mats(2); run_op(-1, 0, 0, 0, 0);
      cur_test = "neg_pos";    set_mats(3); run_op(-1, 0, 0, 0, 0);
      cur_test = "fives";      set_mats(4); run_op(-1, 0, 0, 0, 0);
      cur_test = "eye_eye";    set_mats(5); run_op(-1, 0, 0, 0, 0);
      cur_test = "backpress";  set_mats(0); run_op(3, 5, 0, 0, 0);
      cur_test = "abort";      set_mats(1); run_op(-1, 0, 0, 0, 2 * DIM + 11);
      cur_test = "after_abort"; set_mats(1); run_op(-1, 0, 0, 0, 0);
      cur_test = "start_read"; set_mats(6); run_op(-1, 0, 0, 1, 0);
      for (int n = 0; n < 4; n++) begin
         cur_test = "random";
         set_mats(6);
         run_op(-1, 0, 1, 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for one DIM×DIM signed matrix multiply C = A·B on the systolic MAC array. On a start pulse it:
- flushes stale operands from the array's A/B pipelines and clears every C accumulator;
- streams A columns and B rows from an operand memory with per-lane skew;
- returns the DIM rows of C over a valid/ready stream.

It sits between the operand buffer and the array and owns all array control signals.

## Interface
- BITS_AB, 8, signed operand width
- BITS_C, 16, signed accumulator width
- DIM, 8, array dimension; W = $clog2(DIM)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- start  in  1  begin an operation; honoured only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last C row is accepted
- mem_rd_en  out  1  operand read strobe
- mem_addr  out  W  index k of the operand pair to read
- a_col  in  DIM×BITS_AB  A[0..DIM-1][k]; valid the cycle after mem_rd_en
- b_row  in  DIM×BITS_AB  B[k][0..DIM-1]; same timing as a_col
- sa_en  out  1  array enable
- sa_wren  out  1  array C write enable
- sa_crow  out  W  array row select
- sa_A, sa_B  out  DIM×BITS_AB  array row and column inputs
- sa_Cin  out  DIM×BITS_C  array C write data; always 0
- sa_Cout  in  DIM×BITS_C  array row sa_crow, combinational
- c_valid  out  1  C row available
- c_ready  in  1  consumer accepts the row
- c_row  out  W  index of the presented row
- c_data  out  DIM×BITS_C  the presented row, equal to sa_Cout

## Operation
- States are IDLE, FLUSH, CLEAR, FEED, READ and DONE. Counter cnt is cleared on every state entry.
- **IDLE**
  - All outputs are 0.
  - start=1 moves to FLUSH.
- **FLUSH** (DIM cycles)
  - sa_en=1 and sa_A=sa_B=0, which pushes stale operands out of every PE pipeline register.
- **CLEAR** (DIM cycles)
  - sa_en=0, sa_wren=1, sa_crow=cnt, sa_Cin=0.
  - Every accumulator is 0 on exit.
- **FEED** (3·DIM−1 cycles, t = cnt = 0..3·DIM−2)
  - sa_en=1 on every cycle.
  - mem_rd_en=1 and mem_addr=t for t < DIM.
  - sa_A[i] = a_col[i] of read k when t = k+1+i, otherwise 0.
  - sa_B[j] = b_row[j] of read k when t = k+1+j, otherwise 0.
  - Skew is implemented with lane-i delay lines of depth i; lane 0 gates the memory data directly.
  - The last product, k = i = j = DIM−1, enters PE(DIM−1,DIM−1) at t = 3·DIM−2.
- **READ**
  - sa_en=0, sa_crow=c_row=cnt, c_valid=1, c_data=sa_Cout.
  - On c_valid&c_ready, cnt increments.
  - The handshake at cnt = DIM−1 moves to DONE.
- **DONE** (1 cycle)
  - done=1, busy=1, then IDLE.
- **Arithmetic**
  - The array accumulates signed products, sign-extended to BITS_C.
  - Overflow wraps modulo 2^BITS_C; the controller does no saturation.
- **Boundary conditions**
  - start outside IDLE is ignored.
  - c_ready held low stalls READ indefinitely; c_row and c_data stay stable.
  - rst in any state returns to IDLE next cycle with all outputs 0.
  - Array contents are left untouched on rst; the next FLUSH and CLEAR make any later operation independent of history.

## Timing
- start is sampled at edge 0. Then:
  - FLUSH covers cycles 1..DIM.
  - CLEAR covers DIM+1..2·DIM.
  - FEED covers 2·DIM+1..5·DIM−1.
  - The first c_valid is at cycle 5·DIM.
- With c_ready held high, row r is presented at cycle 5·DIM+r and done is at 6·DIM.
- Latency from start to done is 6·DIM cycles plus stall cycles. For DIM=8 that is 48 cycles.
- busy rises the cycle after start and falls the cycle after done.
- mem_addr is presented 0..DIM−1 on consecutive cycles, with no gaps and no rereads.

## Test plan
- **Identity.** A = I, B[k][j] = 8k+j, DIM=8, c_ready=1 → row r reads 8r..8r+7, done at cycle 48 after start.
- **All ones.** A = B = all 1 → every c_data element is 8. Check mem_rd_en high for exactly 8 cycles with addr 0..7.
- **Signed extremes and wrap.**
  - A = B = all −128 → each element is 131072 mod 2^16 = 0.
  - A = all −128, B = all 127 → each element is 1024.
- **Stale-state independence.** Run A = B = all 5, then immediately run A = I, B = I → the second result is exactly I.
- **Backpressure.** Drop c_ready for 5 cycles while c_row=3 → c_row and c_data hold steady, no row is skipped or duplicated, and done is delayed by 5 cycles.
- **Reset and ignored start.**
  - Assert rst at FEED t=10 → busy=0 and all outputs 0 next cycle; a following all-ones operation still yields 8 everywhere.
  - start pulsed during READ is ignored.
